// File: rtl/hex_display_pkg.sv
// Shared constants and the hex-to-segment decode table for hex_display_scan.
// Segments are active-low and packed as {a,b,c,d,e,f,g}.
package hex_display_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h01;
         4'h1:    s = 7'h4F;
         4'h2:    s = 7'h12;
         4'h3:    s = 7'h06;
         4'h4:    s = 7'h4C;
         4'h5:    s = 7'h24;
         4'h6:    s = 7'h20;
         4'h7:    s = 7'h0F;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h04;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h60;
         4'hC:    s = 7'h31;
         4'hD:    s = 7'h42;
         4'hE:    s = 7'h30;
         default: s = 7'h38;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timing for the display scanner: a prescaler counter that paces the digit index,
// flags the last cycle of each slot and the dead-time window at the start of each slot.
module scan_prescaler #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 2,
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          slot_tick,
   output logic          in_dead,
   output logic [IW-1:0] idx
);

   logic [CW-1:0] cnt;

   assign slot_tick = (cnt == CW'(REFRESH_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (slot_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   generate
      if (DEAD_CYCLES == 0) begin : g_no_dead
         assign in_dead = 1'b0;
      end else begin : g_dead
         assign in_dead = (cnt < CW'(DEAD_CYCLES));
      end

      // A single-digit display never advances the index.
      if (NUM_DIGITS == 1) begin : g_one_digit
         assign idx = '0;
      end else begin : g_multi_digit
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               idx <= '0;
            end else if (slot_tick) begin
               if (idx == IW'(NUM_DIGITS - 1)) begin
                  idx <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/hex_display_scan.sv
// Multiplexed common-anode 7-segment scanner with dead time, blanking, leading-zero
// suppression and load-strobed snapshot. Define HEX_DISPLAY_SCAN_DP_EN for decimal points.
module hex_display_scan
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    lzs,
`ifdef HEX_DISPLAY_SCAN_DP_EN
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic                    dp,
`endif
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    frame_start
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic                    slot_tick;
   logic                    in_dead;
   logic [IW-1:0]           idx;
   logic                    slot_first;
   logic [4*NUM_DIGITS-1:0] value_q;
   logic [NUM_DIGITS-1:0]   upper_zero;
   logic [3:0]              nib;
   logic                    dark;
   logic [NUM_DIGITS-1:0]   an_nxt;
   logic [6:0]              seg_nxt;
   logic                    frame_start_nxt;

   scan_prescaler #(
      .NUM_DIGITS  (NUM_DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_prescaler (
      .clk       (clk),
      .rst_n     (rst_n),
      .slot_tick (slot_tick),
      .in_dead   (in_dead),
      .idx       (idx)
   );

   // Tracks cnt==0 without exposing the counter: the cycle after a tick, or right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_first <= 1'b1;
      end else begin
         slot_first <= slot_tick;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= value;
      end
   end

   always_comb begin
      upper_zero = '0;
      nib        = 4'h0;
      upper_zero[NUM_DIGITS-1] = (value_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         upper_zero[i] = upper_zero[i+1] && (value_q[4*i +: 4] == 4'h0);
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            nib = value_q[4*i +: 4];
         end
      end
   end

   // Blanking wins over everything; lzs never darkens digit 0.
   assign dark = blank_mask[idx] || (lzs && (idx != '0) && upper_zero[idx]);

   always_comb begin
      an_nxt          = '1;
      seg_nxt         = SEG_OFF;
      frame_start_nxt = slot_first && (idx == '0);
      if (!in_dead) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nxt[i] = (idx != IW'(i));
         end
         seg_nxt = dark ? SEG_OFF : seg_decode(nib);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an          <= '1;
         seg         <= SEG_OFF;
         frame_start <= 1'b0;
      end else begin
         an          <= an_nxt;
         seg         <= seg_nxt;
         frame_start <= frame_start_nxt;
      end
   end

`ifdef HEX_DISPLAY_SCAN_DP_EN
   logic [NUM_DIGITS-1:0] dp_mask_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_mask_q <= '0;
         dp        <= 1'b1;
      end else begin
         if (load) begin
            dp_mask_q <= dp_mask;
         end
         dp <= in_dead ? 1'b1 : ~dp_mask_q[idx];
      end
   end
`endif

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Parametrised successor to the single-digit hex-to-7-segment decoder.
- Drives NUM_DIGITS common-anode 7-segment digits via time-multiplexed scanning with a refresh prescaler, anti-ghosting dead time, per-digit blanking, leading-zero suppression and a load-strobed value snapshot.
- Sits between datapath registers and board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=1).
- REFRESH_DIV, 50000, clocks per digit slot (>=2).
- DEAD_CYCLES, 2, clocks at slot start with all digits off (0 <= DEAD_CYCLES < REFRESH_DIV).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i], digit 0 rightmost.
- load  in  1  snapshot strobe.
- blank_mask  in  NUM_DIGITS  bit i=1 forces digit i dark.
- lzs  in  1  leading-zero suppression enable.
- an  out  NUM_DIGITS  active-low one-hot digit enable.
- seg  out  7  active-low segments; seg[6]=a … seg[0]=g.
- frame_start  out  1  one-cycle pulse at start of digit-0 slot.

Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (async assert): value_q=0, cnt=0, idx=0, an=all 1, seg=7'h7F, frame_start=0.
- load=1 at rising edge: value_q<=value. Display always reads value_q. A load mid-slot changes seg on the next edge; there is no slot restart.
- Prescaler cnt counts 0..REFRESH_DIV-1. At cnt==REFRESH_DIV-1: cnt<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 to 0.
- All outputs are registered. an, seg and frame_start reflect the (cnt,idx) of the previous cycle, giving 1-cycle latency.
- Dead time: while cnt<DEAD_CYCLES, an=all 1 and seg=7'h7F.
- Otherwise an[idx]=0 (others 1) and seg=decode(nibble idx of value_q), unless the digit is dark.
- Digit dark (an[idx]=0 still asserted, seg=7'h7F) when either:
  - blank_mask[idx]=1, or
  - lzs=1, idx>0, and nibbles idx..NUM_DIGITS-1 are all zero.
- Digit 0 is never suppressed by lzs (value 0 shows "0"). blank_mask overrides lzs.
- frame_start=1 for exactly one cycle, aligned with the output cycle where cnt==0 and idx==0.
- NUM_DIGITS=1: idx is constant 0 and frame_start pulses every slot.
- blank_mask and lzs are sampled live each cycle, not snapshotted.
- Release of rst_n mid-scan restarts at digit 0, cnt 0.

Optional Feature:
- Macro: HEX_DISPLAY_SCAN_DP_EN.
- Defined:
  - Adds input dp_mask[NUM_DIGITS] and output dp (active-low).
  - dp=~dp_mask[idx] while a digit is active, including dark digits.
  - dp=1 during dead time and reset.
  - dp_mask is captured into value_q's snapshot on load.
- Undefined: no dp_mask/dp ports; behaviour otherwise identical.

Decomposition:
- Package hex_display_pkg:
  - SEG_OFF=7'h7F.
  - Function seg_decode(logic [3:0]) returning active-low a..g: 0 7'h01, 1 7'h4F, 2 7'h12, 3 7'h06, 4 7'h4C, 5 7'h24, 6 7'h20, 7 7'h0F, 8 7'h00, 9 7'h04, A 7'h08, b 7'h60, C 7'h31, d 7'h42, E 7'h30, F 7'h38.
- Sub-module: scan_prescaler (cnt/idx counters, emits slot_tick, in_dead, idx). Decode/blanking logic stays in the top.

Test Plan:
- Reset check: rst_n=0 mid-scan -> immediately an=4'b1111, seg=7'h7F, frame_start=0. After release, the first active slot is an=4'b1110.
- Scan order and dead time (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1):
  - an per clock = 1111,1110,1110,1110,1111,1101,1101,1101,1111,1011, … wraps to 1110.
  - frame_start pulses once every 16 clocks.
- Snapshot: value=16'h1A2F, load pulse.
  - Digits 0..3 show 7'h38, 7'h12, 7'h08, 7'h4F.
  - Changing value without load -> seg unchanged.
- Leading-zero suppression: lzs=1, value_q=16'h0040 -> digits 3 and 2 dark (seg 7'h7F), digit 1 7'h4C, digit 0 7'h01. value_q=0 -> only digit 0 shows 7'h01.
- Blanking: blank_mask=4'b0100, value_q=16'h8888 -> digit 2 dark with an[2]=0 in its slot, other digits 7'h00.
- DP_EN build: dp_mask=4'b0010, load -> dp=0 only during digit-1 active cycles, 1 in dead time and other slots.
